// File: rtl/inv_row_shift_unit.sv
// inv_row_shift_unit: byte-serial AES InvShiftRows stage.
// Collects a 16-byte state in column-major order, applies the inverse row
// rotation and presents the result on a registered 128-bit valid/ready port.
// Optional build macro INV_ROW_SHIFT_DBLBUF_EN adds a separate fill buffer and
// a PEND state so the next block can be collected while a result is waiting.
module inv_row_shift_unit (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic [7:0]   in_byte,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] out_state,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned STATE_W   = 128;
    localparam int unsigned NUM_BYTES = 16;
    localparam int unsigned NUM_ROWS  = 4;
    localparam int unsigned CNT_W     = 4;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

`ifdef INV_ROW_SHIFT_DBLBUF_EN
    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    logic [0:0] state_q, state_d;
`endif

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STATE_W-1:0] fill_q, fill_d;
    logic [STATE_W-1:0] out_state_q, out_state_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;

    logic               accept_c;
    logic               slot_free_c;
    logic               xfer_c;

    // Output byte (r,c) takes input byte (r,(c-r) mod 4); byte k sits at [127-8k -: 8].
    function automatic logic [STATE_W-1:0] inv_shift_rows(input logic [STATE_W-1:0] s);
        logic [STATE_W-1:0] res;
        int dst;
        int src;
        res = '0;
        for (int r = 0; r < int'(NUM_ROWS); r++) begin
            for (int c = 0; c < int'(NUM_ROWS); c++) begin
                dst = int'(NUM_ROWS) * c + r;
                src = int'(NUM_ROWS) * ((c - r + int'(NUM_ROWS)) % int'(NUM_ROWS)) + r;
                res[int'(STATE_W) - 1 - int'(BYTE_W) * dst -: BYTE_W] =
                    s[int'(STATE_W) - 1 - int'(BYTE_W) * src -: BYTE_W];
            end
        end
        return res;
    endfunction

    // Handshake qualifiers; in_ready_q is a pure register so acceptance never
    // depends combinationally on the sink side.
    assign accept_c    = in_valid && in_ready_q && !clr;
    assign slot_free_c = !out_valid_q || out_ready;

    // Next-state: byte insertion, block transfer, output slot and in_ready.
    always_comb begin
        cnt_d       = cnt_q;
        fill_d      = fill_q;
        out_state_d = out_state_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        xfer_c      = 1'b0;
`ifdef INV_ROW_SHIFT_DBLBUF_EN
        state_d     = state_q;
`endif

        if (clr) begin
            cnt_d       = '0;
            out_valid_d = 1'b0;
`ifdef INV_ROW_SHIFT_DBLBUF_EN
            state_d     = ST_FILL;
`endif
        end else begin
            if (accept_c) begin
                for (int k = 0; k < int'(NUM_BYTES); k++) begin
                    if (cnt_q == CNT_W'(k)) begin
                        fill_d[int'(STATE_W) - 1 - int'(BYTE_W) * k -: BYTE_W] = in_byte;
                    end
                end
                cnt_d = cnt_q + CNT_W'(1);
            end

            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end

`ifdef INV_ROW_SHIFT_DBLBUF_EN
            if (state_q == ST_FILL) begin
                if (accept_c && (cnt_q == LAST_IDX)) begin
                    if (slot_free_c) begin
                        xfer_c = 1'b1;
                    end else begin
                        state_d = ST_PEND;
                    end
                end
            end else begin
                if (slot_free_c) begin
                    xfer_c  = 1'b1;
                    state_d = ST_FILL;
                end
            end
`else
            // in_ready tracks !out_valid, so the slot is always free here.
            if (accept_c && (cnt_q == LAST_IDX) && slot_free_c) begin
                xfer_c = 1'b1;
            end
`endif

            // fill_d already holds the 16th byte when the transfer is from FILL.
            if (xfer_c) begin
                out_state_d = inv_shift_rows(fill_d);
                out_valid_d = 1'b1;
            end
        end

`ifdef INV_ROW_SHIFT_DBLBUF_EN
        in_ready_d = (state_d == ST_FILL);
`else
        in_ready_d = !out_valid_d;
`endif
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            fill_q      <= '0;
            out_state_q <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
`ifdef INV_ROW_SHIFT_DBLBUF_EN
            state_q     <= ST_FILL;
`endif
        end else begin
            cnt_q       <= cnt_d;
            fill_q      <= fill_d;
            out_state_q <= out_state_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
`ifdef INV_ROW_SHIFT_DBLBUF_EN
            state_q     <= state_d;
`endif
        end
    end

    assign out_state = out_state_q;
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;

endmodule

// File: tb/tb_inv_row_shift_unit.sv
// Self-checking bench for inv_row_shift_unit (default or INV_ROW_SHIFT_DBLBUF_EN build).
module tb_inv_row_shift_unit;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clr = 1'b0;
    logic [7:0]   in_byte = 8'h00;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] out_state;
    logic         out_valid;
    logic         out_ready = 1'b0;

    always #5 clk = ~clk;

    inv_row_shift_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .in_byte  (in_byte),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_state(out_state),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference InvShiftRows from the (row, column) definition.
    function automatic logic [127:0] ref_isr(input logic [7:0] b [16]);
        logic [127:0] res;
        res = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                res[127 - 8*(4*c + r) -: 8] = b[4*((c - r + 4) % 4) + r];
        return res;
    endfunction

    function automatic logic [127:0] seq_ref(input logic [7:0] base);
        logic [7:0] b [16];
        for (int k = 0; k < 16; k++) b[k] = base + 8'(k);
        return ref_isr(b);
    endfunction

    // Behavioural model: accepted bytes, completed blocks waiting, output slot.
    logic [7:0]   m_part[$];
    logic [127:0] m_done[$];
    logic         m_valid = 1'b0;
    logic [127:0] m_state = '0;
    logic         prev_hold = 1'b0;
    logic [127:0] prev_state = '0;
    int           n_out = 0;
    int           n_vcyc = 0;
    logic [127:0] last_out = '0;

    function automatic logic model_ready();
`ifdef INV_ROW_SHIFT_DBLBUF_EN
        return (m_done.size() == 0);
`else
        return !m_valid;
`endif
    endfunction

    // Compare process: check outputs against the model, then advance the model.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_part.delete();
            m_done.delete();
            m_valid = 1'b0;
            m_state = '0;
            prev_hold = 1'b0;
        end else begin
            logic rdy;
            logic free;
            logic [7:0] blk [16];
            chk("out_valid", out_valid, m_valid);
            if (m_valid) chk("out_state", out_state, m_state);
            chk("in_ready", in_ready, model_ready());
            if (prev_hold) chk("hold_stable", out_state, prev_state);
            if (out_valid) n_vcyc++;
            if (out_valid && out_ready) begin
                n_out++;
                last_out = out_state;
            end
            prev_hold  = out_valid && !out_ready;
            prev_state = out_state;

            if (clr) begin
                m_part.delete();
                m_done.delete();
                m_valid = 1'b0;
            end else begin
                rdy  = model_ready();
                free = !m_valid || out_ready;
                if (in_valid && rdy) begin
                    m_part.push_back(in_byte);
                    if (m_part.size() == 16) begin
                        for (int k = 0; k < 16; k++) blk[k] = m_part[k];
                        m_done.push_back(ref_isr(blk));
                        m_part.delete();
                    end
                end
                if (m_valid && out_ready) m_valid = 1'b0;
                if (free && m_done.size() > 0) begin
                    m_state = m_done.pop_front();
                    m_valid = 1'b1;
                end
            end
        end
    end

    // Stimulus source
    logic [7:0] src_q[$];
    int p_valid = 100;
    int p_ready = 100;
    logic clr_req = 1'b0;
    int n_acc = 0;

    task automatic step();
        @(posedge clk);
        #1;
        out_ready = ($urandom_range(99) < p_ready);
        clr = clr_req;
        if (src_q.size() > 0 && $urandom_range(99) < p_valid) begin
            in_valid = 1'b1;
            in_byte  = src_q[0];
            if (in_ready && !clr) begin
                void'(src_q.pop_front());
                n_acc++;
            end
        end else begin
            in_valid = 1'b0;
            in_byte  = 8'($urandom);
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic push_seq(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) src_q.push_back(base + 8'(i));
    endtask

    task automatic drain_all(input string name, input int budget);
        int cyc;
        logic done;
        cyc = 0;
        done = 1'b0;
        while (!done && cyc < budget) begin
            step();
            cyc++;
            done = (src_q.size() == 0) && !in_valid && (m_done.size() == 0) && !m_valid;
        end
        chk(name, done, 1'b1);
    endtask

    localparam logic [127:0] EXP_A = 128'h000d0a07_04010e0b_0805020f_0c090603;
    localparam logic [127:0] EXP_B = 128'h101d1a17_14111e1b_1815121f_1c191613;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_state", out_state, 128'h0);
        chk("rst_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;

        // Pin the reference model to hand-computed results
        chk("ref_pin_a", seq_ref(8'h00), EXP_A);
        chk("ref_pin_b", seq_ref(8'h10), EXP_B);

        // Single block with a ready sink
        p_valid = 100; p_ready = 100;
        n_out = 0; n_vcyc = 0;
        push_seq(8'h00, 16);
        drain_all("t1_drain", 200);
        run(3);
        chk("t1_out_count", n_out, 1);
        chk("t1_valid_cycles", n_vcyc, 1);
        chk("t1_result", last_out, EXP_A);

        // Two blocks back-to-back against a stalled sink
        p_ready = 0; n_acc = 0;
        push_seq(8'h00, 32);
        run(40);
        chk("t2_in_ready_low", in_ready, 1'b0);
`ifdef INV_ROW_SHIFT_DBLBUF_EN
        chk("t2_accepted", n_acc, 32);
`else
        chk("t2_accepted", n_acc, 16);
`endif
        n_out = 0; p_ready = 100;
        drain_all("t2_drain", 300);
        chk("t2_out_count", n_out, 2);
        chk("t2_second_result", last_out, EXP_B);

        // Clear after 7 bytes discards them
        n_out = 0;
        push_seq(8'ha0, 7);
        drain_all("t3_partial", 100);
        clr_req = 1'b1; step(); clr_req = 1'b0;
        push_seq(8'h00, 16);
        drain_all("t3_drain", 200);
        run(2);
        chk("t3_out_count", n_out, 1);
        chk("t3_result", last_out, EXP_A);

        // Clear coincident with the 16th byte
        n_out = 0;
        push_seq(8'h40, 15);
        drain_all("t6_fill", 100);
        src_q.push_back(8'h4f);
        clr_req = 1'b1; step(); clr_req = 1'b0;
        src_q.delete();
        step();
        chk("t6_no_out", out_valid, 1'b0);
        push_seq(8'h50, 16);
        drain_all("t6_drain", 200);
        run(2);
        chk("t6_out_count", n_out, 1);
        chk("t6_result", last_out, seq_ref(8'h50));

        // Asynchronous reset with a pending output and a partial block
        p_ready = 0;
        push_seq(8'h60, 16);
        push_seq(8'h70, 10);
        run(30);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t4_rst_out_valid", out_valid, 1'b0);
        chk("t4_rst_out_state", out_state, 128'h0);
        chk("t4_rst_in_ready", in_ready, 1'b1);
        src_q.delete();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n = 1'b1;
        p_ready = 100; n_out = 0;
        push_seq(8'h80, 16);
        drain_all("t4_drain", 200);
        run(2);
        chk("t4_out_count", n_out, 1);
        chk("t4_result", last_out, seq_ref(8'h80));

        // Random flow control over 200 random blocks
        p_valid = 60; p_ready = 50; n_out = 0;
        for (int i = 0; i < 200 * 16; i++) src_q.push_back(8'($urandom));
        drain_all("t5_drain", 40000);
        chk("t5_out_count", n_out, 200);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
